// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer for the 1-bit left/right shifter datapath
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic             cmd_rot,
   input  logic [AMT_W-1:0] cmd_amt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_next;
   logic [AMT_W-1:0] remaining;
   logic             dir_q;
   logic             rot_q;

   // Handshake flags depend only on state, so cmd_ready never waits on cmd_valid
   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // One 1-bit shift step; the fill bit is zero for logical or the wrapped bit for rotate
   always_comb begin
      work_next = work;
      if (dir_q == 1'b0) begin
         work_next = {work[WIDTH-2:0], (rot_q ? work[WIDTH-1] : 1'b0)};
      end else begin
         work_next = {(rot_q ? work[0] : 1'b0), work[WIDTH-1:1]};
      end
   end

   // Sequencer: accept in IDLE, shift until remaining is exhausted, hold the result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         work      <= '0;
         remaining <= '0;
         dir_q     <= 1'b0;
         rot_q     <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         done_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  work      <= cmd_data;
                  remaining <= cmd_amt;
                  dir_q     <= cmd_dir;
                  rot_q     <= cmd_rot;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (remaining == '0) begin
                  res_data  <= work;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  work      <= work_next;
                  remaining <= remaining - AMT_ONE;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  done_cnt  <= done_cnt + CNT_ONE;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard testbench for shift_seq_ctrl
module tb_shift_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int AMT_W = 3;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_dir;
   logic             cmd_rot;
   logic [AMT_W-1:0] cmd_amt;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] tmp;

   shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_rot   (cmd_rot),
      .cmd_amt   (cmd_amt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic dir,
                                              input logic rot, input int amt);
      logic [WIDTH-1:0] w;
      w = d;
      for (int i = 0; i < amt; i++) begin
         if (!dir) w = {w[WIDTH-2:0], (rot ? w[WIDTH-1] : 1'b0)};
         else      w = {(rot ? w[0] : 1'b0), w[WIDTH-1:1]};
      end
      return w;
   endfunction

   // Called #1 after an edge; drives a command and returns #1 after its accept edge.
   task automatic send_cmd(input logic [WIDTH-1:0] d, input logic dir, input logic rot,
                           input int amt, input bit keep_valid);
      int guard;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_data  = d;
      cmd_dir   = dir;
      cmd_rot   = rot;
      cmd_amt   = AMT_W'(amt);
      cmd_valid = 1'b1;
      exp_q.push_back(model(d, dir, rot, amt));
      @(posedge clk); #1;
      if (!keep_valid) cmd_valid = 1'b0;
   endtask

   // Waits for the result, checks latency and data, optionally stalls, then handshakes.
   task automatic get_result(input int amt, input int stall);
      int lat;
      logic [WIDTH-1:0] exp;
      lat = 0;
      while (!res_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("latency", lat, amt + 1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check_eq("res_data", {28'd0, res_data}, {28'd0, exp});
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check_eq("stall_data", {28'd0, res_data}, {28'd0, exp});
         check_eq("stall_valid", {31'd0, res_valid}, 32'd1);
         check_eq("stall_ready", {31'd0, cmd_ready}, 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      check_eq("done_cnt", {24'd0, done_cnt}, {24'd0, exp_cnt});
      check_eq("valid_drop", {31'd0, res_valid}, 32'd0);
      check_eq("ready_back", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt = '0;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0;
      cmd_rot = 1'b0; cmd_amt = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check_eq("rst_res_data", {28'd0, res_data}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done_cnt", {24'd0, done_cnt}, 32'd0);
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // Reset while shifting a 7-step command aborts it without counting
      send_cmd(4'b0101, 1'b0, 1'b1, 7, 1'b0);
      repeat (3) @(posedge clk);
      #1 check_eq("mid_busy", {31'd0, busy}, 32'd1);
      do_reset();
      check_eq("abort_res_valid", {31'd0, res_valid}, 32'd0);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("abort_done_cnt", {24'd0, done_cnt}, 32'd0);

      // Directed shift cases
      send_cmd(4'b0001, 1'b0, 1'b0, 1, 1'b0); check_eq("dir_exp_1", {28'd0, exp_q[0]}, 32'h2); get_result(1, 0);
      send_cmd(4'b1000, 1'b1, 1'b0, 3, 1'b0); get_result(3, 0);
      send_cmd(4'b0100, 1'b0, 1'b0, 3, 1'b0); get_result(3, 0);
      send_cmd(4'b1001, 1'b0, 1'b1, 1, 1'b0); get_result(1, 0);
      send_cmd(4'b1001, 1'b0, 1'b1, 4, 1'b0); get_result(4, 0);
      send_cmd(4'b0001, 1'b1, 1'b1, 1, 1'b0); get_result(1, 0);
      send_cmd(4'b1111, 1'b1, 1'b0, 7, 1'b0); get_result(7, 0);
      send_cmd(4'b0110, 1'b1, 1'b1, 6, 1'b0); get_result(6, 0);

      // Backpressure: result held 5 cycles while another command waits
      send_cmd(4'b0011, 1'b0, 1'b0, 2, 1'b1);
      cmd_data = 4'b1010; cmd_dir = 1'b1; cmd_rot = 1'b1; cmd_amt = 3'd0;
      get_result(2, 5);
      exp_q.push_back(4'b1010);
      @(posedge clk); #1;
      check_eq("late_accept_busy", {31'd0, busy}, 32'd1);
      check_eq("late_accept_ready", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b0;
      get_result(0, 0);

      // Random commands
      for (int i = 0; i < 20; i++) begin
         int a;
         a = $urandom_range(0, 7);
         send_cmd(WIDTH'($urandom), 1'($urandom), 1'($urandom), a, 1'b0);
         get_result(a, $urandom_range(0, 2));
      end

      // 256 zero-amount commands wrap the counter back through 255 -> 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         tmp = WIDTH'($urandom);
         send_cmd(tmp, 1'($urandom), 1'($urandom), 0, 1'b0);
         get_result(0, 0);
      end
      check_eq("wrap_cnt", {24'd0, done_cnt}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
